// File: rtl/ip_pkt_pkg.sv
// ip_pkt_pkg: Ethernet/IPv4 frame layout constants and rx FSM state type,
// shared by the accelerator's IPv4 receive and transmit paths.
package ip_pkt_pkg;

    typedef enum logic [2:0] {
        IDLE           = 3'd0,
        RECV_ETH_HDR   = 3'd1,
        RECV_IP_HDR    = 3'd2,
        RECV_USER_DATA = 3'd3,
        DISCARD        = 3'd4,
        HOLD           = 3'd5
    } rx_state_e;

    localparam logic [7:0]  ETH_SRC_OFS    = 8'd6;
    localparam logic [7:0]  ETHERTYPE_OFS  = 8'd12;
    localparam logic [7:0]  IP_HDR_OFS     = 8'd14;
    localparam logic [7:0]  IP_SRC_OFS     = 8'd26;
    localparam logic [7:0]  IP_DST_OFS     = 8'd30;
    localparam logic [7:0]  PAYLOAD_OFS    = 8'd34;
    localparam logic [7:0]  FRAME_LEN      = 8'd36;

    localparam logic [15:0] ETHERTYPE_IPV4 = 16'h0800;
    localparam logic [7:0]  IP_VER_IHL     = 8'h45;
    localparam logic [47:0] BCAST_MAC      = 48'hFFFF_FFFF_FFFF;

    // 16-bit ones-complement add; a single end-around carry cannot overflow again.
    function automatic logic [15:0] ones_add(input logic [15:0] a, input logic [15:0] b);
        logic [16:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[15:0] + {15'd0, s[16]};
    endfunction

endpackage

// File: rtl/ip_hdr_checksum.sv
// ip_hdr_checksum: byte-serial 16-bit ones-complement accumulator (big-endian words).
// Built only when IP_RX_CHECKSUM_EN is defined.
`ifdef IP_RX_CHECKSUM_EN
module ip_hdr_checksum
    import ip_pkt_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        clr,
    input  logic        en,
    input  logic [7:0]  data_in,
    output logic [15:0] sum_next
);

    logic [15:0] sum_q, sum_d;
    logic [7:0]  hi_q, hi_d;
    logic        odd_q, odd_d;

    // Sum including the current byte, so the final word can be judged on its own beat.
    assign sum_next = odd_q ? ones_add(sum_q, {hi_q, data_in}) : sum_q;

    always_comb begin
        sum_d = sum_q;
        hi_d  = hi_q;
        odd_d = odd_q;
        if (clr) begin
            sum_d = '0;
            hi_d  = '0;
            odd_d = 1'b0;
        end else if (en) begin
            if (odd_q) sum_d = sum_next;
            else       hi_d  = data_in;
            odd_d = ~odd_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sum_q <= '0;
            hi_q  <= '0;
            odd_q <= 1'b0;
        end else begin
            sum_q <= sum_d;
            hi_q  <= hi_d;
            odd_q <= odd_d;
        end
    end

endmodule
`endif

// File: rtl/ip_packet_rx.sv
// ip_packet_rx: parses Ethernet+IPv4 frames from an 8-bit MAC stream and hands accepted
// messages to the accelerator. Define IP_RX_CHECKSUM_EN to also verify the IPv4 header checksum.
module ip_packet_rx
    import ip_pkt_pkg::*;
#(
    parameter int AXI_S_DATA_WIDTH = 8,
    parameter int IP_ADDR_WIDTH    = 32,
    parameter int MAC_ADDR_WIDTH   = 48,
    parameter int ACCEL_DATA_WIDTH = 10,
    parameter bit ACCEPT_BROADCAST = 1'b1
) (
    input  logic                        aclk,
    input  logic                        areset,
    input  logic [IP_ADDR_WIDTH-1:0]    ACCELERATOR_IP_ADDRESS,
    input  logic [MAC_ADDR_WIDTH-1:0]   ACCELERATOR_MAC_ADDRESS,
    input  logic [AXI_S_DATA_WIDTH-1:0] MAC_DATA_IN,
    input  logic                        MAC_DATA_VALID,
    output logic                        MAC_DATA_READY,
    input  logic                        MAC_DATA_FIRST,
    input  logic                        MAC_DATA_LAST,
    output logic [IP_ADDR_WIDTH-1:0]    SENDER_IP_ADDRESS,
    output logic [MAC_ADDR_WIDTH-1:0]   SENDER_MAC_ADDRESS,
    output logic [ACCEL_DATA_WIDTH-1:0] RECEIVED_MESSAGE,
    output logic                        MESSAGE_VALID,
    input  logic                        MESSAGE_ACCEPT,
    output logic [7:0]                  DROP_COUNT
);

    rx_state_e                   state_q, state_d;
    logic [7:0]                  cnt_q, cnt_d;
    logic [MAC_ADDR_WIDTH-9:0]   dst_mac_q, dst_mac_d;
    logic [IP_ADDR_WIDTH-9:0]    dst_ip_q, dst_ip_d;
    logic [MAC_ADDR_WIDTH-1:0]   src_mac_q, src_mac_d;
    logic [IP_ADDR_WIDTH-1:0]    src_ip_q, src_ip_d;
    logic [1:0]                  msg_hi_q, msg_hi_d;
    logic [IP_ADDR_WIDTH-1:0]    sender_ip_q, sender_ip_d;
    logic [MAC_ADDR_WIDTH-1:0]   sender_mac_q, sender_mac_d;
    logic [ACCEL_DATA_WIDTH-1:0] message_q, message_d;
    logic                        valid_q, valid_d;
    logic [7:0]                  drop_q, drop_d;

    logic                        beat;
    logic                        parse;
    logic [7:0]                  idx;
    logic [7:0]                  nxt;
    logic                        field_fail;
    logic [1:0]                  drop_inc;
    logic [8:0]                  drop_sum;
    logic [MAC_ADDR_WIDTH-1:0]   dst_mac_full;
    logic [IP_ADDR_WIDTH-1:0]    dst_ip_full;

    assign MAC_DATA_READY     = (state_q != HOLD);
    assign beat               = MAC_DATA_VALID && MAC_DATA_READY;
    assign dst_mac_full       = {dst_mac_q, MAC_DATA_IN};
    assign dst_ip_full        = {dst_ip_q, MAC_DATA_IN};
    assign SENDER_IP_ADDRESS  = sender_ip_q;
    assign SENDER_MAC_ADDRESS = sender_mac_q;
    assign RECEIVED_MESSAGE   = message_q;
    assign MESSAGE_VALID      = valid_q;
    assign DROP_COUNT         = drop_q;

`ifdef IP_RX_CHECKSUM_EN
    logic [15:0] csum_next;
    logic        csum_clr;
    logic        csum_en;

    assign csum_clr = parse && (idx == '0);
    assign csum_en  = parse && (idx >= IP_HDR_OFS) && (idx < PAYLOAD_OFS);

    ip_hdr_checksum u_csum (
        .clk      (aclk),
        .rst      (areset),
        .clr      (csum_clr),
        .en       (csum_en),
        .data_in  (MAC_DATA_IN),
        .sum_next (csum_next)
    );
`endif

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        dst_mac_d    = dst_mac_q;
        dst_ip_d     = dst_ip_q;
        src_mac_d    = src_mac_q;
        src_ip_d     = src_ip_q;
        msg_hi_d     = msg_hi_q;
        sender_ip_d  = sender_ip_q;
        sender_mac_d = sender_mac_q;
        message_d    = message_q;
        valid_d      = valid_q;
        parse        = 1'b0;
        idx          = cnt_q;
        nxt          = cnt_q;
        field_fail   = 1'b0;
        drop_inc     = 2'd0;

        // A FIRST beat mid-frame drops the old frame and restarts parsing at byte 0.
        case (state_q)
            HOLD: begin
                if (valid_q && MESSAGE_ACCEPT) begin
                    valid_d = 1'b0;
                    state_d = IDLE;
                end
            end
            IDLE: begin
                if (beat && MAC_DATA_FIRST) begin
                    parse = 1'b1;
                    idx   = '0;
                end
            end
            DISCARD: begin
                if (beat) begin
                    if (MAC_DATA_FIRST) begin
                        drop_inc = 2'd1;
                        parse    = 1'b1;
                        idx      = '0;
                    end else if (MAC_DATA_LAST) begin
                        drop_inc = 2'd1;
                        state_d  = IDLE;
                        cnt_d    = '0;
                    end
                end
            end
            default: begin
                if (beat) begin
                    parse = 1'b1;
                    if (MAC_DATA_FIRST) begin
                        drop_inc = 2'd1;
                        idx      = '0;
                    end
                end
            end
        endcase

        if (parse) begin
            if (idx < ETH_SRC_OFS - 8'd1)
                dst_mac_d = {dst_mac_q[MAC_ADDR_WIDTH-17:0], MAC_DATA_IN};
            if (idx == ETH_SRC_OFS - 8'd1)
                field_fail = !((dst_mac_full == ACCELERATOR_MAC_ADDRESS) ||
                               (ACCEPT_BROADCAST && (dst_mac_full == BCAST_MAC)));
            if ((idx >= ETH_SRC_OFS) && (idx < ETHERTYPE_OFS))
                src_mac_d = {src_mac_q[MAC_ADDR_WIDTH-9:0], MAC_DATA_IN};
            if (idx == ETHERTYPE_OFS)
                field_fail = (MAC_DATA_IN != ETHERTYPE_IPV4[15:8]);
            if (idx == ETHERTYPE_OFS + 8'd1)
                field_fail = (MAC_DATA_IN != ETHERTYPE_IPV4[7:0]);
            if (idx == IP_HDR_OFS)
                field_fail = (MAC_DATA_IN != IP_VER_IHL);
            if ((idx >= IP_SRC_OFS) && (idx < IP_DST_OFS))
                src_ip_d = {src_ip_q[IP_ADDR_WIDTH-9:0], MAC_DATA_IN};
            if ((idx >= IP_DST_OFS) && (idx < PAYLOAD_OFS - 8'd1))
                dst_ip_d = {dst_ip_q[IP_ADDR_WIDTH-17:0], MAC_DATA_IN};
            if (idx == PAYLOAD_OFS - 8'd1)
                field_fail = (dst_ip_full != ACCELERATOR_IP_ADDRESS);
`ifdef IP_RX_CHECKSUM_EN
            if ((idx == PAYLOAD_OFS - 8'd1) && (csum_next != 16'hFFFF))
                field_fail = 1'b1;
`endif
            if (idx == PAYLOAD_OFS)
                msg_hi_d = MAC_DATA_IN[1:0];

            nxt   = idx + 8'd1;
            cnt_d = nxt;
            if (MAC_DATA_LAST) begin
                cnt_d = '0;
                if ((idx == FRAME_LEN - 8'd1) && !field_fail) begin
                    sender_ip_d  = src_ip_q;
                    sender_mac_d = src_mac_q;
                    message_d    = {msg_hi_q, MAC_DATA_IN};
                    valid_d      = 1'b1;
                    state_d      = HOLD;
                end else begin
                    drop_inc = drop_inc + 2'd1;
                    state_d  = IDLE;
                end
            end else if (field_fail || (idx == FRAME_LEN - 8'd1)) begin
                state_d = DISCARD;
            end else if (nxt < IP_HDR_OFS) begin
                state_d = RECV_ETH_HDR;
            end else if (nxt < PAYLOAD_OFS) begin
                state_d = RECV_IP_HDR;
            end else begin
                state_d = RECV_USER_DATA;
            end
        end

        drop_sum = {1'b0, drop_q} + {7'd0, drop_inc};
        drop_d   = drop_sum[8] ? 8'hFF : drop_sum[7:0];
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            dst_mac_q    <= '0;
            dst_ip_q     <= '0;
            src_mac_q    <= '0;
            src_ip_q     <= '0;
            msg_hi_q     <= '0;
            sender_ip_q  <= '0;
            sender_mac_q <= '0;
            message_q    <= '0;
            valid_q      <= 1'b0;
            drop_q       <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            dst_mac_q    <= dst_mac_d;
            dst_ip_q     <= dst_ip_d;
            src_mac_q    <= src_mac_d;
            src_ip_q     <= src_ip_d;
            msg_hi_q     <= msg_hi_d;
            sender_ip_q  <= sender_ip_d;
            sender_mac_q <= sender_mac_d;
            message_q    <= message_d;
            valid_q      <= valid_d;
            drop_q       <= drop_d;
        end
    end

endmodule

// File: tb/tb_ip_packet_rx.sv
// tb_ip_packet_rx: scoreboard bench for ip_packet_rx; frames are judged by a byte-queue
// reference model and delivered messages are checked by an independent monitor.
module tb_ip_packet_rx;

    typedef logic [7:0] bq_t [$];
    typedef struct packed {
        logic [31:0] ip;
        logic [47:0] mac;
        logic [9:0]  msg;
    } exp_t;

    localparam logic [47:0] OWN_MAC = 48'h02_00_00_00_00_01;
    localparam logic [31:0] OWN_IP  = 32'h0A_00_00_02;

    logic        aclk = 1'b0;
    logic        areset = 1'b1;
    logic [7:0]  MAC_DATA_IN = '0;
    logic        MAC_DATA_VALID = 1'b0;
    logic        MAC_DATA_READY;
    logic        MAC_DATA_FIRST = 1'b0;
    logic        MAC_DATA_LAST = 1'b0;
    logic [31:0] SENDER_IP_ADDRESS;
    logic [47:0] SENDER_MAC_ADDRESS;
    logic [9:0]  RECEIVED_MESSAGE;
    logic        MESSAGE_VALID;
    logic        MESSAGE_ACCEPT = 1'b0;
    logic [7:0]  DROP_COUNT;

    int   total = 0;
    int   bad = 0;
    int   exp_drop = 0;
    int   accept_delay = -1;
    exp_t exp_q [$];

    always #5 aclk = ~aclk;

    ip_packet_rx #(.ACCEPT_BROADCAST(1'b1)) dut (
        .aclk                    (aclk),
        .areset                  (areset),
        .ACCELERATOR_IP_ADDRESS  (OWN_IP),
        .ACCELERATOR_MAC_ADDRESS (OWN_MAC),
        .MAC_DATA_IN             (MAC_DATA_IN),
        .MAC_DATA_VALID          (MAC_DATA_VALID),
        .MAC_DATA_READY          (MAC_DATA_READY),
        .MAC_DATA_FIRST          (MAC_DATA_FIRST),
        .MAC_DATA_LAST           (MAC_DATA_LAST),
        .SENDER_IP_ADDRESS       (SENDER_IP_ADDRESS),
        .SENDER_MAC_ADDRESS      (SENDER_MAC_ADDRESS),
        .RECEIVED_MESSAGE        (RECEIVED_MESSAGE),
        .MESSAGE_VALID           (MESSAGE_VALID),
        .MESSAGE_ACCEPT          (MESSAGE_ACCEPT),
        .DROP_COUNT              (DROP_COUNT)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, want, $time);
        end
    endtask

    function automatic logic [15:0] ones_sum(input bq_t f);
        int unsigned s;
        s = 0;
        for (int i = 0; i < 10; i++) s += {16'h0, f[14 + 2*i], f[15 + 2*i]};
        while (s > 32'hFFFF) s = (s & 32'hFFFF) + (s >> 16);
        return s[15:0];
    endfunction

    function automatic bq_t fix_csum(input bq_t f);
        bq_t         g;
        logic [15:0] cs;
        g = f;
        g[24] = 8'h00;
        g[25] = 8'h00;
        cs = ~ones_sum(g);
        g[24] = cs[15:8];
        g[25] = cs[7:0];
        return g;
    endfunction

    function automatic bq_t make_good(input logic [47:0] smac, input logic [31:0] sip,
                                      input logic [9:0] msg);
        bq_t          f;
        logic [287:0] v;
        logic [5:0]   r6;
        logic [15:0]  id;
        r6 = 6'($urandom);
        id = 16'($urandom);
        v = {OWN_MAC, smac, 16'h0800, 8'h45, 8'h00, 16'd22, id, 16'h4000, 8'h40, 8'h11,
             16'h0000, sip, OWN_IP, r6, msg[9:8], msg[7:0]};
        for (int i = 0; i < 36; i++) f.push_back(v[287 - 8*i -: 8]);
        return fix_csum(f);
    endfunction

    function automatic bit model_accept(input bq_t f);
        logic [47:0] dmac;
        logic [31:0] dip;
        if (f.size() != 36) return 1'b0;
        dmac = {f[0], f[1], f[2], f[3], f[4], f[5]};
        dip  = {f[30], f[31], f[32], f[33]};
        if (dmac != OWN_MAC && dmac != 48'hFFFF_FFFF_FFFF) return 1'b0;
        if ({f[12], f[13]} != 16'h0800) return 1'b0;
        if (f[14] != 8'h45) return 1'b0;
        if (dip != OWN_IP) return 1'b0;
`ifdef IP_RX_CHECKSUM_EN
        if (ones_sum(f) != 16'hFFFF) return 1'b0;
`endif
        return 1'b1;
    endfunction

    function automatic exp_t exp_of(input bq_t f);
        exp_t       e;
        logic [7:0] b34;
        b34   = f[34];
        e.ip  = {f[26], f[27], f[28], f[29]};
        e.mac = {f[6], f[7], f[8], f[9], f[10], f[11]};
        e.msg = {b34[1:0], f[35]};
        return e;
    endfunction

    task automatic send_byte(input logic [7:0] b, input bit f, input bit l, input bit gaps);
        int unsigned guard;
        if (gaps) repeat ($urandom_range(0, 2)) @(negedge aclk);
        guard = 0;
        while (!MAC_DATA_READY && guard < 200) begin
            @(negedge aclk);
            guard++;
        end
        if (!MAC_DATA_READY) begin
            check("ready_timeout", 64'd0, 64'd1);
            return;
        end
        MAC_DATA_IN    = b;
        MAC_DATA_FIRST = f;
        MAC_DATA_LAST  = l;
        MAC_DATA_VALID = 1'b1;
        @(negedge aclk);
        MAC_DATA_VALID = 1'b0;
        MAC_DATA_FIRST = 1'b0;
        MAC_DATA_LAST  = 1'b0;
    endtask

    task automatic send_partial(input bq_t f, input int n);
        for (int i = 0; i < n; i++) send_byte(f[i], i == 0, 1'b0, 1'b0);
    endtask

    task automatic run_frame(input bq_t f, input bit gaps);
        bit acc;
        acc = model_accept(f);
        if (acc) exp_q.push_back(exp_of(f));
        else if (exp_drop < 255) exp_drop++;
        for (int i = 0; i < f.size(); i++)
            send_byte(f[i], i == 0, i == f.size() - 1, gaps);
        check(acc ? "valid_latency" : "no_valid_on_drop", 64'(MESSAGE_VALID), 64'(acc));
        check("drop_count", 64'(DROP_COUNT), 64'(exp_drop));
    endtask

    task automatic wait_drain();
        int unsigned guard;
        guard = 0;
        while ((exp_q.size() != 0 || MESSAGE_VALID) && guard < 300) begin
            @(negedge aclk);
            guard++;
        end
        check("drain", 64'(exp_q.size()), 64'd0);
    endtask

    // Monitor: compares each presented message, then holds it for a while before accepting.
    initial begin : monitor
        exp_t        e;
        int          d;
        logic [31:0] s_ip;
        logic [47:0] s_mac;
        logic [9:0]  s_msg;
        forever begin
            @(negedge aclk);
            if (!areset && MESSAGE_VALID) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_message", 64'd1, 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("sender_ip", 64'(SENDER_IP_ADDRESS), 64'(e.ip));
                    check("sender_mac", 64'(SENDER_MAC_ADDRESS), 64'(e.mac));
                    check("message", 64'(RECEIVED_MESSAGE), 64'(e.msg));
                end
                s_ip  = SENDER_IP_ADDRESS;
                s_mac = SENDER_MAC_ADDRESS;
                s_msg = RECEIVED_MESSAGE;
                d = (accept_delay < 0) ? int'($urandom_range(0, 3)) : accept_delay;
                for (int i = 0; i < d; i++) begin
                    @(negedge aclk);
                    check("hold_valid", 64'(MESSAGE_VALID), 64'd1);
                    check("hold_ready", 64'(MAC_DATA_READY), 64'd0);
                    check("hold_ip", 64'(SENDER_IP_ADDRESS), 64'(s_ip));
                    check("hold_mac", 64'(SENDER_MAC_ADDRESS), 64'(s_mac));
                    check("hold_msg", 64'(RECEIVED_MESSAGE), 64'(s_msg));
                end
                MESSAGE_ACCEPT = 1'b1;
                @(negedge aclk);
                MESSAGE_ACCEPT = 1'b0;
                check("valid_clear", 64'(MESSAGE_VALID), 64'd0);
            end
        end
    end

    initial begin : watchdog
        #800000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin : stimulus
        bq_t f;
        bq_t g;
        int  k;
        int  len;

        repeat (3) @(negedge aclk);
        areset = 1'b0;
        check("rst_ready", 64'(MAC_DATA_READY), 64'd1);
        check("rst_valid", 64'(MESSAGE_VALID), 64'd0);
        check("rst_ip", 64'(SENDER_IP_ADDRESS), 64'd0);
        check("rst_mac", 64'(SENDER_MAC_ADDRESS), 64'd0);
        check("rst_msg", 64'(RECEIVED_MESSAGE), 64'd0);
        check("rst_drop", 64'(DROP_COUNT), 64'd0);

        // Directed good frame: message 0x3FF from 02:AA:BB:CC:DD:EE / 10.0.0.9.
        f = make_good(48'h02_AA_BB_CC_DD_EE, 32'h0A_00_00_09, 10'h3FF);
        f[34] = 8'h03;
        run_frame(f, 1'b0);
        wait_drain();

        // Long hold with a second frame waiting behind it.
        accept_delay = 10;
        run_frame(f, 1'b0);
        g = make_good(48'h02_11_22_33_44_55, 32'h0A_00_00_07, 10'h155);
        run_frame(g, 1'b0);
        wait_drain();
        accept_delay = -1;

        // Wrong dst IP, wrong ethertype, truncated at byte 20, then a good frame.
        f = make_good(48'h02_AA_BB_CC_DD_EE, 32'h0A_00_00_09, 10'h001);
        f[33] = 8'h03;
        run_frame(fix_csum(f), 1'b0);
        f = make_good(48'h02_AA_BB_CC_DD_EE, 32'h0A_00_00_09, 10'h002);
        f[12] = 8'h86;
        f[13] = 8'hDD;
        run_frame(f, 1'b0);
        f = make_good(48'h02_AA_BB_CC_DD_EE, 32'h0A_00_00_09, 10'h003);
        while (f.size() > 21) void'(f.pop_back());
        run_frame(f, 1'b0);
        check("three_drops", 64'(DROP_COUNT), 64'd3);
        run_frame(make_good(48'h02_01_02_03_04_05, 32'hC0_A8_01_01, 10'h2A5), 1'b0);
        wait_drain();

        // FIRST reasserted at byte 17.
        f = make_good(48'h02_AA_BB_CC_DD_EE, 32'h0A_00_00_09, 10'h0F0);
        send_partial(f, 17);
        if (exp_drop < 255) exp_drop++;
        run_frame(make_good(48'h02_66_77_88_99_AA, 32'h0A_00_00_0B, 10'h30C), 1'b0);
        wait_drain();

        // Reset at byte 30; tail bytes arrive without FIRST and must be eaten.
        f = make_good(48'h02_AA_BB_CC_DD_EE, 32'h0A_00_00_09, 10'h111);
        send_partial(f, 30);
        areset = 1'b1;
        @(negedge aclk);
        areset = 1'b0;
        exp_drop = 0;
        for (int i = 30; i < 36; i++) send_byte(f[i], 1'b0, i == 35, 1'b0);
        check("reset_no_valid", 64'(MESSAGE_VALID), 64'd0);
        check("reset_drop", 64'(DROP_COUNT), 64'd0);
        run_frame(make_good(48'h02_12_34_56_78_9A, 32'h0A_00_00_0C, 10'h222), 1'b0);
        wait_drain();

        // Corrupted checksum byte: dropped only when the checksum is verified.
        f = make_good(48'h02_AA_BB_CC_DD_EE, 32'h0A_00_00_09, 10'h333);
        f[25] = f[25] ^ 8'h5A;
        run_frame(f, 1'b0);
        wait_drain();

        // Randomized frames with occasional corruption.
        for (int n = 0; n < 150; n++) begin
            f = make_good(48'({$urandom, $urandom}), 32'($urandom), 10'($urandom));
            case ($urandom_range(0, 9))
                0: begin k = $urandom_range(0, 5);   f[k] = f[k] ^ 8'(1 << $urandom_range(0, 7)); end
                1: for (int i = 0; i < 6; i++) f[i] = 8'hFF;
                2: begin k = $urandom_range(12, 13); f[k] = f[k] ^ 8'(1 << $urandom_range(0, 7)); end
                3: f[14] = f[14] ^ 8'(1 << $urandom_range(0, 7));
                4: begin k = $urandom_range(30, 33); f[k] = f[k] ^ 8'(1 << $urandom_range(0, 7)); end
                5: begin
                    len = $urandom_range(1, 35);
                    while (f.size() > len) void'(f.pop_back());
                end
                6: repeat ($urandom_range(1, 4)) f.push_back(8'($urandom));
                7: begin k = $urandom_range(15, 25); f[k] = f[k] ^ 8'(1 << $urandom_range(0, 7)); end
                8: f[34] = {6'($urandom), f[34][1:0]};
                default: ;
            endcase
            run_frame(f, 1'b1);
        end
        wait_drain();

        // Drive the drop counter into saturation.
        for (int n = 0; n < 300; n++) begin
            f.delete();
            repeat (3) f.push_back(8'($urandom));
            run_frame(f, 1'b0);
        end
        check("drop_saturated", 64'(DROP_COUNT), 64'd255);

        run_frame(make_good(48'h02_FE_DC_BA_98_76, 32'h0A_00_00_0D, 10'h1C7), 1'b0);
        wait_drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
